// File: rtl/hiscore_ioctl_player.sv
// Plays cfg/dump byte images into hiscore's ioctl port as downloads and captures uploads.
// Optional running byte checksum is enabled by defining HS_PLAYER_CHECKSUM_EN.
module hiscore_ioctl_player #(
  parameter int CFG_INDEX   = 3,
  parameter int DUMP_INDEX  = 4,
  parameter int IMG_AW      = 8,
  parameter int WR_GAP      = 3,
  parameter int UPLOAD_WAIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [IMG_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic              start_cfg,
  input  logic              start_dump,
  input  logic              start_upload,
  input  logic [IMG_AW:0]   cfg_len,
  input  logic [IMG_AW:0]   xfer_len,
  input  logic [IMG_AW-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic [7:0]        checksum,
  output logic              ioctl_download,
  output logic              ioctl_upload,
  output logic              ioctl_wr,
  output logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_dout,
  output logic [7:0]        ioctl_index,
  input  logic [7:0]        ioctl_din
);

  typedef enum logic [3:0] {
    IDLE, SETUP, FETCH, WR, GAP, UL_ADDR, UL_WAIT, UL_CAP, FINISH
  } state_t;

  localparam logic [IMG_AW:0] MAX_LEN   = {1'b1, {IMG_AW{1'b0}}};
  localparam logic [15:0]     GAP_LAST  = 16'(WR_GAP - 1);
  localparam logic [15:0]     WAIT_LAST = 16'(UPLOAD_WAIT - 1);
  localparam int              DEPTH     = 1 << IMG_AW;

  state_t            state_q, state_d;
  logic [IMG_AW:0]   n_q, n_d;
  logic [IMG_AW:0]   len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              dl_q, dl_d;
  logic              ul_q, ul_d;
  logic              sel_q, sel_d;
  logic [7:0]        index_q, index_d;
  logic [7:0]        img_q, img_d;
  logic [7:0]        rd_q, rd_d;

  logic              start_any;
  logic              start_ul;
  logic              start_sel;
  logic [7:0]        start_index;
  logic [IMG_AW:0]   raw_len;
  logic [IMG_AW:0]   start_len;
  logic [IMG_AW:0]   n_inc;
  logic              last_byte;
  logic              advance;

  logic [7:0] cfg_ram  [DEPTH];
  logic [7:0] dump_ram [DEPTH];
  logic [7:0] cap_ram  [DEPTH];

  // Start arbitration: cfg wins over dump, dump over upload; oversize lengths clamp to the RAM depth.
  always_comb begin
    start_any   = start_cfg | start_dump | start_upload;
    start_ul    = 1'b0;
    start_sel   = 1'b1;
    start_index = 8'(DUMP_INDEX);
    raw_len     = xfer_len;
    if (start_cfg) begin
      start_sel   = 1'b0;
      start_index = 8'(CFG_INDEX);
      raw_len     = cfg_len;
    end else if (!start_dump) begin
      start_ul = 1'b1;
    end
    start_len = (raw_len > MAX_LEN) ? MAX_LEN : raw_len;
  end

  assign n_inc     = n_q + 1'b1;
  assign last_byte = (n_inc == len_q);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dl_d    = dl_q;
    ul_d    = ul_q;
    sel_d   = sel_q;
    index_d = index_q;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_any) begin
          if (start_len == '0) begin
            state_d = FINISH;
          end else begin
            state_d = SETUP;
            n_d     = '0;
            len_d   = start_len;
            sel_d   = start_sel;
            index_d = start_index;
            dl_d    = !start_ul;
            ul_d    = start_ul;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ul_q ? UL_ADDR : FETCH;
      end
      FETCH: state_d = WR;
      WR: begin
        cnt_d = '0;
        if (WR_GAP == 0) advance = 1'b1;
        else             state_d = GAP;
      end
      GAP: begin
        if (cnt_q == GAP_LAST) advance = 1'b1;
        else                   cnt_d = 16'(cnt_q + 16'd1);
      end
      UL_ADDR: begin
        cnt_d   = '0;
        state_d = (UPLOAD_WAIT == 0) ? UL_CAP : UL_WAIT;
      end
      UL_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = UL_CAP;
        else                    cnt_d = 16'(cnt_q + 16'd1);
      end
      UL_CAP: advance = 1'b1;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Byte complete: step the counter and either loop or wrap up the transfer.
    if (advance) begin
      n_d = n_inc;
      if (last_byte) begin
        state_d = FINISH;
        dl_d    = 1'b0;
        ul_d    = 1'b0;
      end else begin
        state_d = ul_q ? UL_ADDR : FETCH;
      end
    end
  end

  always_comb begin
    img_d = img_q;
    if (state_q == FETCH) img_d = sel_q ? dump_ram[n_q[IMG_AW-1:0]] : cfg_ram[n_q[IMG_AW-1:0]];
    rd_d = cap_ram[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dl_q    <= 1'b0;
      ul_q    <= 1'b0;
      sel_q   <= 1'b0;
      index_q <= '0;
      img_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
      ul_q    <= ul_d;
      sel_q   <= sel_d;
      index_q <= index_d;
      img_q   <= img_d;
      rd_q    <= rd_d;
    end
  end

  // RAM contents survive reset; reset forces IDLE so no capture write can occur while it is held.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) begin
      if (ld_sel) dump_ram[ld_addr] <= ld_data;
      else        cfg_ram[ld_addr]  <= ld_data;
    end
    if (state_q == UL_CAP) cap_ram[n_q[IMG_AW-1:0]] <= ioctl_din;
  end

`ifdef HS_PLAYER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start_any && start_len != '0) csum_d = 8'h00;
    else if (state_q == WR)                              csum_d = csum_q + img_q;
    else if (state_q == UL_CAP)                          csum_d = csum_q + ioctl_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 8'h00;
`endif

  assign busy           = (state_q != IDLE) && (state_q != FINISH);
  assign done           = (state_q == FINISH);
  assign ioctl_wr       = (state_q == WR);
  assign ioctl_addr     = {{(24 - IMG_AW){1'b0}}, n_q};
  assign ioctl_dout     = img_q;
  assign ioctl_index    = index_q;
  assign ioctl_download = dl_q;
  assign ioctl_upload   = ul_q;
  assign rd_data        = rd_q;

endmodule
